// File: rtl/llspi_arbiter.sv
// llspi_arbiter
//   Shares one llspi host port between NREQ requesters. A requester is granted
//   for exactly one burst (round-robin). Its command words are forwarded to
//   llspi with a configurable idle gap between write strobes. After the SPI
//   engine goes idle, the expected number of result bytes is collected and
//   routed back to the owner. Any surplus bytes left in the llspi result FIFO
//   are read and discarded before the port is released.
//
// Ports
//   lb_clk, rst_n           clock, asynchronous active-low reset
//   req_valid/ready/data/   per-requester command stream (9-bit words,
//   req_last/req_rcnt         last-of-burst flag, result byte count)
//   grant                   one-hot current owner, 0 when idle
//   rsp_valid/rsp_data      per-requester result strobe, shared result byte
//   rsp_err                 per-requester strobe: burst ended on result timeout
//   llspi_*                 connection to the llspi host interface
//   flush_count             saturating count of discarded surplus bytes
module llspi_arbiter #(
  parameter int NREQ    = 2,
  parameter int CMD_GAP = 1,
  parameter int TMO_W   = 12
) (
  input  logic              lb_clk,
  input  logic              rst_n,
  input  logic [NREQ-1:0]   req_valid,
  output logic [NREQ-1:0]   req_ready,
  input  logic [9*NREQ-1:0] req_data,
  input  logic [NREQ-1:0]   req_last,
  input  logic [4*NREQ-1:0] req_rcnt,
  output logic [NREQ-1:0]   grant,
  output logic [NREQ-1:0]   rsp_valid,
  output logic [7:0]        rsp_data,
  output logic [NREQ-1:0]   rsp_err,
  output logic [8:0]        llspi_host_din,
  output logic              llspi_we,
  input  logic              llspi_busy,
  input  logic              llspi_result_avail,
  output logic              llspi_re,
  input  logic [7:0]        llspi_result,
  output logic [7:0]        flush_count
);

  localparam int IW = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam int GW = (CMD_GAP > 0) ? $clog2(CMD_GAP + 1) : 1;
  // Last timeout count value before the timeout fires (2**TMO_W-1 cycles total).
  localparam logic [TMO_W-1:0] TMO_LAST = {{(TMO_W-1){1'b1}}, 1'b0};

  typedef enum logic [2:0] {S_IDLE, S_ISSUE, S_DRAIN, S_COLLECT, S_FLUSH} state_t;

  state_t            state_reg, state_next;
  logic [NREQ-1:0]   grant_reg, grant_next;
  logic [IW-1:0]     idx_reg, idx_next;
  logic [IW-1:0]     rr_reg, rr_next;
  logic [3:0]        rcnt_reg, rcnt_next;
  logic [GW-1:0]     gap_reg, gap_next;
  logic [1:0]        drain_reg, drain_next;
  logic [TMO_W-1:0]  tmo_reg, tmo_next;
  logic [8:0]        din_reg, din_next;
  logic              we_reg, we_next;
  logic              re_reg, re_next;
  logic              pend_reg;          // result byte on llspi_result this cycle
  logic [NREQ-1:0]   rsp_valid_reg, rsp_valid_next;
  logic [7:0]        rsp_data_reg, rsp_data_next;
  logic [NREQ-1:0]   rsp_err_reg, rsp_err_next;
  logic [7:0]        flush_reg, flush_next;

  // Round-robin pick: first valid requester at or after rr, in wrap order.
  logic              pick_found;
  logic [IW-1:0]     pick_idx;
  logic [NREQ-1:0]   pick_onehot;
  int                pick_j;

  always_comb begin
    pick_found  = 1'b0;
    pick_idx    = '0;
    pick_onehot = '0;
    pick_j      = 0;
    for (int k = 0; k < NREQ; k++) begin
      pick_j = int'(rr_reg) + k;
      if (pick_j >= NREQ) pick_j = pick_j - NREQ;
      if (!pick_found && req_valid[pick_j]) begin
        pick_found          = 1'b1;
        pick_idx            = IW'(pick_j);
        pick_onehot[pick_j] = 1'b1;
      end
    end
  end

  logic [8:0] sel_data;
  logic       sel_last;
  logic       accept;

  assign sel_data  = req_data[9*int'(idx_reg) +: 9];
  assign sel_last  = req_last[idx_reg];
  assign req_ready = (state_reg == S_ISSUE && gap_reg == '0) ? grant_reg : '0;
  assign accept    = |(req_valid & req_ready);

  always_comb begin
    state_next     = state_reg;
    grant_next     = grant_reg;
    idx_next       = idx_reg;
    rr_next        = rr_reg;
    rcnt_next      = rcnt_reg;
    gap_next       = gap_reg;
    drain_next     = drain_reg;
    tmo_next       = tmo_reg;
    din_next       = din_reg;
    we_next        = 1'b0;
    re_next        = 1'b0;
    rsp_valid_next = '0;
    rsp_data_next  = rsp_data_reg;
    rsp_err_next   = '0;
    flush_next     = flush_reg;

    case (state_reg)
      S_IDLE: begin
        if (pick_found) begin
          grant_next = pick_onehot;
          idx_next   = pick_idx;
          rcnt_next  = req_rcnt[4*int'(pick_idx) +: 4];
          gap_next   = '0;
          state_next = S_ISSUE;
        end
      end

      S_ISSUE: begin
        if (accept) begin
          din_next = sel_data;
          we_next  = 1'b1;
          gap_next = GW'(CMD_GAP);
          if (sel_last) begin
            drain_next = '0;
            state_next = S_DRAIN;
          end
        end else if (gap_reg != '0) begin
          gap_next = gap_reg - 1'b1;
        end
      end

      S_DRAIN: begin
        // llspi raises busy a couple of cycles after the last write strobe,
        // so give it time before trusting busy==0.
        if (drain_reg != 2'd2) begin
          drain_next = drain_reg + 2'd1;
        end else if (!llspi_busy) begin
          tmo_next   = '0;
          state_next = (rcnt_reg == 4'd0) ? S_FLUSH : S_COLLECT;
        end
      end

      S_COLLECT: begin
        if (pend_reg) begin
          rsp_data_next  = llspi_result;
          rsp_valid_next = grant_reg;
          rcnt_next      = rcnt_reg - 4'd1;
          tmo_next       = '0;
          if (rcnt_reg == 4'd1) state_next = S_FLUSH;
          else if (llspi_result_avail) re_next = 1'b1;
        end else begin
          if (!re_reg && llspi_result_avail) re_next = 1'b1;
          if (tmo_reg == TMO_LAST) begin
            rsp_err_next = grant_reg;
            state_next   = S_FLUSH;
          end else begin
            tmo_next = tmo_reg + 1'b1;
          end
        end
      end

      S_FLUSH: begin
        // A read may still be in flight from COLLECT (timeout path); it is
        // counted as discarded when its data arrives.
        if (pend_reg && flush_reg != 8'hFF) flush_next = flush_reg + 8'd1;
        if (!re_reg && llspi_result_avail) begin
          re_next = 1'b1;
        end else if (!re_reg && !pend_reg && !llspi_result_avail) begin
          grant_next = '0;
          rr_next    = (idx_reg == IW'(NREQ - 1)) ? '0 : idx_reg + 1'b1;
          state_next = S_IDLE;
        end
      end

      default: state_next = S_IDLE;
    endcase
  end

  always_ff @(posedge lb_clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg     <= S_IDLE;
      grant_reg     <= '0;
      idx_reg       <= '0;
      rr_reg        <= '0;
      rcnt_reg      <= '0;
      gap_reg       <= '0;
      drain_reg     <= '0;
      tmo_reg       <= '0;
      din_reg       <= '0;
      we_reg        <= 1'b0;
      re_reg        <= 1'b0;
      pend_reg      <= 1'b0;
      rsp_valid_reg <= '0;
      rsp_data_reg  <= '0;
      rsp_err_reg   <= '0;
      flush_reg     <= '0;
    end else begin
      state_reg     <= state_next;
      grant_reg     <= grant_next;
      idx_reg       <= idx_next;
      rr_reg        <= rr_next;
      rcnt_reg      <= rcnt_next;
      gap_reg       <= gap_next;
      drain_reg     <= drain_next;
      tmo_reg       <= tmo_next;
      din_reg       <= din_next;
      we_reg        <= we_next;
      re_reg        <= re_next;
      pend_reg      <= re_reg;
      rsp_valid_reg <= rsp_valid_next;
      rsp_data_reg  <= rsp_data_next;
      rsp_err_reg   <= rsp_err_next;
      flush_reg     <= flush_next;
    end
  end

  assign grant          = grant_reg;
  assign rsp_valid      = rsp_valid_reg;
  assign rsp_data       = rsp_data_reg;
  assign rsp_err        = rsp_err_reg;
  assign llspi_host_din = din_reg;
  assign llspi_we       = we_reg;
  assign llspi_re       = re_reg;
  assign flush_count    = flush_reg;

endmodule
